// File: rtl/spi_apb_pkg.sv
// Shared types and decode constants for the SPI-to-APB requester.
package spi_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [1:0]  SLV0      = 2'b00;
  localparam logic [1:0]  SLV1      = 2'b01;
  localparam int unsigned DEC_MSB   = 19;
  localparam logic [15:0] ERR_RDATA = 16'h0000;
  localparam logic [1:0]  PSEL_NONE = 2'b00;

  // Map the two top address bits onto a one-hot select; zero means unmapped.
  function automatic logic [1:0] decode_psel(input logic [1:0] field);
    logic [1:0] sel;
    case (field)
      SLV0:    sel = 2'b01;
      SLV1:    sel = 2'b10;
      default: sel = PSEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Counts ACCESS cycles and flags the cycle in which the limit is reached.
module apb_timeout_cnt #(
  parameter int unsigned TIMEOUT = 32,
  parameter int unsigned TO_W    = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  logic [TO_W-1:0] count;

  // Cycle counter, cleared ahead of each ACCESS phase.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + TO_W'(1);
    end
  end

  // Fires in the ACCESS cycle whose end brings the count up to TIMEOUT.
  assign expired_c = (TIMEOUT != 0) && en && (count == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/spi_apb_master.sv
// APB4 requester: one SPI command in, one APB transfer, one response out.
module spi_apb_master
  import spi_apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 32,
  parameter int unsigned TO_W    = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [1:0]          psel,
  output logic                penable,
  output logic [ADDR_W-1:0]   paddr,
  output logic                pwrite,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr
);

  state_t     state;
  logic [1:0] dec_sel_c;
  logic       to_expired_c;
  logic       to_clr_c;
  logic       to_en_c;

  assign dec_sel_c = decode_psel(cmd_addr[DEC_MSB -: 2]);
  assign cmd_ready = (state == IDLE) && !reset;
  assign to_clr_c  = (state == SETUP);
  assign to_en_c   = (state == ACCESS);

  apb_timeout_cnt #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .clr       (to_clr_c),
    .en        (to_en_c),
    .expired_c (to_expired_c)
  );

  // Transfer sequencer with registered APB and response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      psel      <= '0;
      penable   <= 1'b0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      pstrb     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            if (dec_sel_c != PSEL_NONE) begin
              psel   <= dec_sel_c;
              paddr  <= cmd_addr;
              pwrite <= cmd_write;
              pwdata <= cmd_wdata;
              pstrb  <= cmd_write ? cmd_strb : '0;
              state  <= SETUP;
            end else begin
              // Unmapped: answer immediately without touching the bus.
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= DATA_W'(ERR_RDATA);
              state     <= RESP;
            end
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          // A late pready still beats the timeout in the same cycle.
          if (pready) begin
            psel      <= '0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= pslverr;
            rsp_rdata <= pwrite ? '0 : prdata;
            state     <= RESP;
          end else if (to_expired_c) begin
            psel      <= '0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= DATA_W'(ERR_RDATA);
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_apb_master.sv
// Self-checking bench for spi_apb_master with a behavioural response model.
module tb_spi_apb_master;

  localparam int unsigned ADDR_W  = 20;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned TIMEOUT = 32;
  localparam int unsigned TO_W    = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [1:0]        cmd_strb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [1:0]        psel;
  logic              penable;
  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [1:0]        pstrb;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  int errors = 0;
  int checks = 0;

  spi_apb_master #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_strb  (cmd_strb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .paddr     (paddr),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .pstrb     (pstrb),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected outcome of one command, straight from the address map and timeout rule.
  task automatic model(input logic wr, input logic [ADDR_W-1:0] addr, input int dly,
                       input logic serr, input logic [DATA_W-1:0] rd,
                       output logic [1:0] sel, output logic err,
                       output logic [DATA_W-1:0] rdata, output int n_acc);
    int region;
    region = int'(addr / (1 << 18));
    if (region == 0)      sel = 2'b01;
    else if (region == 1) sel = 2'b10;
    else                  sel = 2'b00;
    if (sel == 2'b00) begin
      err = 1'b1; rdata = '0; n_acc = 0;
    end else if (TIMEOUT != 0 && dly >= int'(TIMEOUT)) begin
      err = 1'b1; rdata = '0; n_acc = int'(TIMEOUT);
    end else begin
      err = serr; rdata = wr ? '0 : rd; n_acc = dly + 1;
    end
  endtask

  // Issues one command from IDLE, plays the APB slave, then drains the response.
  task automatic run_txn(input logic wr, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wd, input logic [1:0] sb,
                         input int dly, input logic serr, input logic [DATA_W-1:0] rd,
                         input int hold);
    logic [1:0]        e_sel;
    logic              e_err;
    logic [DATA_W-1:0] e_rdata;
    logic [1:0]        e_strb;
    int                n_acc;
    model(wr, addr, dly, serr, rd, e_sel, e_err, e_rdata, n_acc);
    e_strb = wr ? sb : 2'b00;

    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_strb = sb;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom); cmd_addr = ADDR_W'($urandom);
    cmd_wdata = DATA_W'($urandom); cmd_strb = 2'($urandom);

    if (e_sel != 2'b00) begin
      chk("setup_psel", 32'(psel), 32'(e_sel));
      chk("setup_penable", 32'(penable), 32'd0);
      chk("setup_paddr", 32'(paddr), 32'(addr));
      chk("setup_pwrite", 32'(pwrite), 32'(wr));
      chk("setup_pstrb", 32'(pstrb), 32'(e_strb));
      if (wr) chk("setup_pwdata", 32'(pwdata), 32'(wd));
      chk("setup_rsp_valid", 32'(rsp_valid), 32'd0);
      for (int k = 1; k <= n_acc; k++) begin
        @(posedge clk); #1;
        chk("acc_psel", 32'(psel), 32'(e_sel));
        chk("acc_penable", 32'(penable), 32'd1);
        chk("acc_paddr", 32'(paddr), 32'(addr));
        chk("acc_pwrite", 32'(pwrite), 32'(wr));
        chk("acc_pstrb", 32'(pstrb), 32'(e_strb));
        if (wr) chk("acc_pwdata", 32'(pwdata), 32'(wd));
        chk("acc_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("acc_cmd_ready", 32'(cmd_ready), 32'd0);
        if (k == dly + 1) begin
          pready = 1'b1; pslverr = serr; prdata = rd;
        end else begin
          pready = 1'b0; pslverr = 1'($urandom); prdata = DATA_W'($urandom);
        end
      end
      @(posedge clk); #1;
      pready = 1'b0; pslverr = 1'b0; prdata = DATA_W'($urandom);
    end

    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_err", 32'(rsp_err), 32'(e_err));
    chk("rsp_rdata", 32'(rsp_rdata), 32'(e_rdata));
    chk("rsp_psel", 32'(psel), 32'd0);
    chk("rsp_penable", 32'(penable), 32'd0);
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1; cmd_write = 1'($urandom);
      cmd_addr = ADDR_W'($urandom_range(0, 32'h3FFFF));
      @(posedge clk); #1;
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_err", 32'(rsp_err), 32'(e_err));
      chk("hold_rsp_rdata", 32'(rsp_rdata), 32'(e_rdata));
      chk("hold_psel", 32'(psel), 32'd0);
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("done_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("done_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("done_psel", 32'(psel), 32'd0);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_strb = '0; rsp_ready = 1'b0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_paddr", 32'(paddr), 32'd0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    chk("rst_pwdata", 32'(pwdata), 32'd0);
    chk("rst_pstrb", 32'(pstrb), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Directed cases.
    run_txn(1'b1, 20'h00010, 16'h1234, 2'b11, 0, 1'b0, 16'h5A5A, 0);
    run_txn(1'b0, 20'h40020, 16'h0000, 2'b11, 3, 1'b0, 16'hABCD, 0);
    run_txn(1'b0, 20'h00100, 16'h0000, 2'b00, 1, 1'b1, 16'h7E57, 3);
    run_txn(1'b1, 20'h80000, 16'hFFFF, 2'b11, 0, 1'b0, 16'h0000, 1);
    run_txn(1'b0, 20'hC1234, 16'h0000, 2'b00, 0, 1'b0, 16'h1111, 0);
    run_txn(1'b0, 20'h40000, 16'h0000, 2'b00, 40, 1'b0, 16'h2222, 0);
    run_txn(1'b1, 20'h00004, 16'h9876, 2'b01, 31, 1'b1, 16'h3333, 0);
    run_txn(1'b0, 20'h7FFFE, 16'h0000, 2'b00, 31, 1'b0, 16'hBEEF, 0);

    // Reset pulse in the middle of an ACCESS phase.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 20'h00200; cmd_strb = 2'b11;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_penable", 32'(penable), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_psel", 32'(psel), 32'd0);
    chk("midrst_penable", 32'(penable), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_paddr", 32'(paddr), 32'd0);
    reset = 1'b0;
    pready = 1'b1; prdata = 16'hDEAD;
    #1;
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
      chk("midrst_no_psel", 32'(psel), 32'd0);
    end
    pready = 1'b0;
    run_txn(1'b0, 20'h40044, 16'h0000, 2'b00, 2, 1'b0, 16'hC0DE, 5);

    // Randomized commands against the model.
    for (int n = 0; n < 40; n++) begin
      logic              r_wr;
      logic [ADDR_W-1:0] r_addr;
      int                r_dly;
      r_wr   = 1'($urandom);
      r_addr = ADDR_W'($urandom);
      if ($urandom_range(0, 3) != 0) r_addr[19] = 1'b0;
      r_dly  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(30, 35)) : int'($urandom_range(0, 4));
      run_txn(r_wr, r_addr, DATA_W'($urandom), 2'($urandom), r_dly, 1'($urandom),
              DATA_W'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
